// File: rtl/bcd_display_scanner.sv
// Latches a multi-digit BCD sum with its carry-out and scans it onto a
// common-anode 7-segment display: guard blanking, zero suppression, bad-digit flag.
module bcd_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  carry_in,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  err
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic                  carry_q, carry_d;
    logic                  load_ack_q, load_ack_d;
    logic                  err_q, err_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic [3:0]            digit [DIGITS];
    logic [3:0]            next_digit [DIGITS];
    logic [DIGITS-1:0]     zero_from;
    logic [3:0]            cur_digit;
    logic                  blanked;
    logic                  carry_on;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_unpack
            assign digit[gi]      = disp_q[4*gi +: 4];
            assign next_digit[gi] = disp_d[4*gi +: 4];
        end
    endgenerate

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    // zero_from[i]: every latched digit from i up to the most significant is zero
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run && (digit[i] == 4'd0);
            zero_from[i] = run;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        disp_d     = load ? bcd_in : disp_q;
        carry_d    = load ? carry_in : carry_q;
        load_ack_d = load;

        // Computed from the incoming value so err moves together with load_ack
        err_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (next_digit[i] > 4'd9) err_d = 1'b1;
        end
    end

    always_comb begin
        cur_digit = digit[idx_q];
        blanked   = blank_lz && (idx_q != '0) && zero_from[idx_q];
        carry_on  = carry_q && (idx_q == LAST_IDX);
        an_d      = '1;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        if (cnt_q >= GUARD_C) begin
            if (!blanked) begin
                an_d[idx_q] = 1'b0;
                seg_d       = seg_decode(cur_digit);
            end
            // Carry lights the top anode with dp even when its digit is suppressed
            if (carry_on) begin
                an_d[idx_q] = 1'b0;
                dp_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            carry_q    <= 1'b0;
            load_ack_q <= 1'b0;
            err_q      <= 1'b0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            carry_q    <= carry_d;
            load_ack_q <= load_ack_d;
            err_q      <= err_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign load_ack = load_ack_q;
    assign err      = err_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGITS=4, PRESCALE=4, GUARD=2.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        carry_in;
    logic        blank_lz;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Bench-side scan position, used only to know which slot is on screen
    int m_cnt;
    int m_idx;

    bcd_display_scanner #(.DIGITS(4), .PRESCALE(4), .GUARD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bcd_in   (bcd_in),
        .carry_in (carry_in),
        .blank_lz (blank_lz),
        .load_ack (load_ack),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_idx <= 0;
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_idx <= (m_idx + 1) % 4;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until the outputs show the first active cycle of slot k
    task automatic to_active(input int k);
        int n = 0;
        while (!(m_cnt == 2 && m_idx == k) && n < 20) begin
            tick();
            n++;
        end
        check("slot_reach", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic c);
        bcd_in   = v;
        carry_in = c;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        $display("load bcd=%04h carry=%0d ack=%0d err=%0d", v, c, load_ack, err);
        check("load_ack_hi", load_ack, 1);
    endtask

    initial begin
        logic [3:0] exp_an;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        carry_in = 1'b0;
        blank_lz = 1'b0;
        repeat (3) tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_err", err, 0);
        check("rst_ack", load_ack, 0);

        // First scan after release: cycle c reflects cnt/idx of cycle c-1
        rst_n = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            exp_an = 4'hF;
            if (((c - 1) % 4) >= 2) exp_an[((c - 1) / 4) % 4] = 1'b0;
            check($sformatf("scan_an_c%0d", c), an, exp_an);
            if (c == 3) check("scan_seg_c3", seg, 7'h40);
        end

        // Load and decode with zero suppression
        blank_lz = 1'b1;
        do_load(16'h0127, 1'b0);
        tick();
        check("load_ack_lo", load_ack, 0);
        to_active(0); check("d0_an", an, 4'hE); check("d0_seg", seg, 7'h78);
        to_active(1); check("d1_an", an, 4'hD); check("d1_seg", seg, 7'h24);
        to_active(2); check("d2_an", an, 4'hB); check("d2_seg", seg, 7'h79);
        to_active(3); check("d3_an", an, 4'hF); check("d3_seg", seg, 7'h7F);
        check("d3_dp", dp, 1);

        // Carry display
        do_load(16'h0000, 1'b1);
        to_active(0); check("c0_seg", seg, 7'h40); check("c0_an", an, 4'hE);
        to_active(1); check("c1_an", an, 4'hF);
        to_active(2); check("c2_an", an, 4'hF);
        to_active(3); check("c3_an", an, 4'h7); check("c3_seg", seg, 7'h7F);
        check("c3_dp", dp, 0);
        blank_lz = 1'b0;
        to_active(3); check("c3nb_seg", seg, 7'h40); check("c3nb_dp", dp, 0);
        check("c3nb_an", an, 4'h7);

        // Invalid digit
        do_load(16'h00A3, 1'b0);
        check("err_set", err, 1);
        to_active(1); check("bad_seg", seg, 7'h3F); check("bad_an", an, 4'hD);
        check("err_hold", err, 1);
        do_load(16'h0093, 1'b0);
        check("err_clr", err, 0);

        // Asynchronous reset in the middle of digit 2's active window
        to_active(2);
        check("pre_rst_an", an, 4'hB);
        #2 rst_n = 1'b0;
        #1;
        check("arst_an", an, 4'hF);
        check("arst_seg", seg, 7'h7F);
        check("arst_err", err, 0);
        tick();
        rst_n = 1'b1;
        tick(); check("rs_c1_an", an, 4'hF);
        tick(); check("rs_c2_an", an, 4'hF);
        tick(); check("rs_c3_an", an, 4'hE); check("rs_c3_seg", seg, 7'h40);
        for (int k = 1; k < 4; k++) begin
            to_active(k);
            check($sformatf("rs_d%0d_seg", k), seg, 7'h40);
        end

        // Back-to-back loads
        bcd_in = 16'h1111; load = 1'b1;
        tick(); check("b2b_ack1", load_ack, 1);
        bcd_in = 16'h2222;
        tick(); check("b2b_ack2", load_ack, 1);
        bcd_in = 16'h3333;
        tick(); check("b2b_ack3", load_ack, 1);
        load = 1'b0;
        $display("load burst 1111,2222,3333 ack=%0d", load_ack);
        tick(); check("b2b_ack_lo", load_ack, 0);
        for (int k = 0; k < 4; k++) begin
            to_active(k);
            check($sformatf("b2b_d%0d_seg", k), seg, 7'h30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
